frame_sequencer: RTL

//  Per-frame controller around the image-processing datapath (window control -> box blur -> output FIFO).

---
 rtl/frame_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Per-frame controller for the window -> blur -> output FIFO datapath.
// Gates upstream tready, counts input/output beats against the fixed frame
// sizes, marks tlast, runs a drain watchdog and raises a level interrupt.
module frame_sequencer #(
  parameter int IMG_PIX = 262144,
  parameter int OUT_PIX = 262144,
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 65535
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic             o_in_beat,
  input  logic             i_prog_full,
  input  logic             i_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_intr,
  input  logic             i_intr_ack,
  output logic             o_err_timeout,
  output logic             o_err_stray,
  output logic [CNT_W-1:0] o_in_count,
  output logic [CNT_W-1:0] o_out_count
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              in_done_q, in_done_d;
  logic              out_done_q, out_done_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              intr_q, intr_d;
  logic              err_to_q, err_to_d;
  logic              err_stray_q, err_stray_d;

  logic active, out_hs, out_beat;

  assign active      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign o_s_ready   = (state_q == S_RUN) && !in_done_q && !i_prog_full;
  assign o_in_beat   = i_s_valid && o_s_ready;
  assign out_hs      = i_out_valid && i_out_ready;
  // beats past the frame size are not counted, so counters saturate
  assign out_beat    = out_hs && active && !out_done_q;
  assign o_out_last  = i_out_valid && active && (out_cnt_q == CNT_W'(OUT_PIX - 1));

  assign o_busy        = active;
  assign o_intr        = intr_q;
  assign o_err_timeout = err_to_q;
  assign o_err_stray   = err_stray_q;
  assign o_in_count    = in_cnt_q;
  assign o_out_count   = out_cnt_q;

  // Next-state: beat counting, done flags, watchdog, state transitions
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    in_done_d   = in_done_q;
    out_done_d  = out_done_q;
    wd_d        = wd_q;
    err_to_d    = err_to_q;
    err_stray_d = err_stray_q;

    if (o_in_beat) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (in_cnt_q == CNT_W'(IMG_PIX - 1)) in_done_d = 1'b1;
    end
    if (out_beat) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if (out_cnt_q == CNT_W'(OUT_PIX - 1)) out_done_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_RUN;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          in_done_d   = 1'b0;
          out_done_d  = 1'b0;
          wd_d        = '0;
          err_to_d    = 1'b0;
          err_stray_d = 1'b0;
        end
      end
      S_RUN: begin
        // decide on the updated flags so a joint final beat skips DRAIN
        if (in_done_d && out_done_d) state_d = S_DONE;
        else if (in_done_d)          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        wd_d = out_hs ? '0 : wd_q + 1'b1;
        if (out_done_d) begin
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (wd_d == WD_W'(TIMEOUT))) begin
          state_d  = S_DONE;
          err_to_d = 1'b1;
        end
      end
      S_DONE: begin
        if (i_intr_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // output traffic while no frame is active is flagged, never counted
    if (out_hs && !active) err_stray_d = 1'b1;

    intr_d = (state_d == S_DONE);
  end

  // State register, async active-high reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      in_done_q   <= 1'b0;
      out_done_q  <= 1'b0;
      wd_q        <= '0;
      intr_q      <= 1'b0;
      err_to_q    <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      in_done_q   <= in_done_d;
      out_done_q  <= out_done_d;
      wd_q        <= wd_d;
      intr_q      <= intr_d;
      err_to_q    <= err_to_d;
      err_stray_q <= err_stray_d;
    end
  end

endmodule
